hazard_ctrl: RTL and testbench

Pipeline hazard and flush sequencer for the 5-stage MIPS core. Sits in ID beside `control`: it detects load-use and branch-operand hazards and sequences multi-cycle stalls through a small FSM. It drives PC/IF-ID write enables, the IF/ID flush, and `control`'s `c_clearControl` bubble input. After reset it also runs a boot drain so the pipeline starts from bubbles.

---
 rtl/hazard_ctrl_if.sv | 49 ++++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the ID-stage hazard inputs and the pipeline
// control outputs of hazard_ctrl into one bundle.
//   slave  : seen from hazard_ctrl (hazard inputs in, control outputs out)
//   master : seen from the pipeline/bench driving the hazard inputs
// Signals:
//   instru_id[31:0]      instruction in ID
//   idex_memread         MemRead of the EX instruction
//   idex_regwrite        RegWrite of the EX instruction
//   idex_wreg[4:0]       destination register of the EX instruction
//   exmem_memread        MemRead of the MEM instruction
//   exmem_wreg[4:0]      destination register of the MEM instruction
//   branch_taken         ID-stage branch decision
//   jump                 jump from control
//   pc_write             PC write enable
//   ifid_write           IF/ID write enable
//   c_clearControl       bubble into ID/EX
//   if_flush             zero IF/ID on next edge
//   stall_cycles[31:0]   stall cycle count (HAZARD_PERF_CNT_EN only, else 0)
//   flush_count[31:0]    IF flush count (HAZARD_PERF_CNT_EN only, else 0)
interface hazard_ctrl_if;
  logic [31:0] instru_id;
  logic        idex_memread;
  logic        idex_regwrite;
  logic [4:0]  idex_wreg;
  logic        exmem_memread;
  logic [4:0]  exmem_wreg;
  logic        branch_taken;
  logic        jump;
  logic        pc_write;
  logic        ifid_write;
  logic        c_clearControl;
  logic        if_flush;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport slave (
    input  instru_id, idex_memread, idex_regwrite, idex_wreg,
           exmem_memread, exmem_wreg, branch_taken, jump,
    output pc_write, ifid_write, c_clearControl, if_flush,
           stall_cycles, flush_count
  );

  modport master (
    output instru_id, idex_memread, idex_regwrite, idex_wreg,
           exmem_memread, exmem_wreg, branch_taken, jump,
    input  pc_write, ifid_write, c_clearControl, if_flush,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-operand hazard detection and stall/flush
// sequencing for the 5-stage MIPS core, plus a post-reset boot drain.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   hz     hazard_ctrl_if.slave (hazard inputs, pipeline control outputs)
// Parameter:
//   BOOT_CYCLES  bubble-injection cycles after reset (1..15)
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> stall_cycles / flush_count performance counters are built
//   undefined -> both counter outputs are tied to 0
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | post-reset drain: bubbles + IF flush, cnt counts down to 0
// RUN   | normal issue; stalls in place for 1-cycle hazards
// STALL | extra stall cycles of a 2-cycle hazard, hazard inputs ignored
module hazard_ctrl #(
  parameter int BOOT_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       uses_rt, is_br;
  logic       ex_hit, mem_hit;
  logic [1:0] stall_n;

  logic       pc_write_c, ifid_write_c, clr_c, if_flush_c;

  logic       unused_bits;
  assign unused_bits = ^hz.instru_id[15:0];

  assign opcode  = hz.instru_id[31:26];
  assign rs      = hz.instru_id[25:21];
  assign rt      = hz.instru_id[20:16];
  assign uses_rt = (opcode == 6'b000000) || (opcode == 6'b000100) ||
                   (opcode == 6'b000101) || (opcode == 6'b101011);
  assign is_br   = (opcode == 6'b000100) || (opcode == 6'b000101);

  assign ex_hit  = (hz.idex_wreg != 5'd0) &&
                   ((hz.idex_wreg == rs) || (uses_rt && (hz.idex_wreg == rt)));
  assign mem_hit = (hz.exmem_wreg != 5'd0) &&
                   ((hz.exmem_wreg == rs) || (uses_rt && (hz.exmem_wreg == rt)));

  // Priority order matters: a branch behind a load in EX needs the longest wait.
  always_comb begin
    stall_n = 2'd0;
    if (is_br && hz.idex_memread && ex_hit)
      stall_n = 2'd2;
    else if (is_br && hz.idex_regwrite && ex_hit)
      stall_n = 2'd1;
    else if (is_br && hz.exmem_memread && mem_hit)
      stall_n = 2'd1;
    else if (hz.idex_memread && ex_hit)
      stall_n = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      cnt_q   <= 4'(BOOT_CYCLES - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write_c   = 1'b0;
    ifid_write_c = 1'b0;
    clr_c        = 1'b1;
    if_flush_c   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if_flush_c = 1'b1;
        if (cnt_q == 4'd0)
          state_d = ST_RUN;
        else
          cnt_d = cnt_q - 4'd1;
      end
      ST_RUN: begin
        if (stall_n == 2'd0) begin
          pc_write_c   = 1'b1;
          ifid_write_c = 1'b1;
          clr_c        = 1'b0;
          if_flush_c   = hz.branch_taken | hz.jump;
        end else if (stall_n == 2'd2) begin
          // This RUN cycle is the first stall; cnt holds the STALL cycles left.
          cnt_d   = 4'd1;
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        // Leave once the last remaining stall cycle is being spent.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_BOOT;
        cnt_d   = 4'(BOOT_CYCLES - 1);
      end
    endcase
  end

  assign hz.pc_write       = pc_write_c;
  assign hz.ifid_write     = ifid_write_c;
  assign hz.c_clearControl = clr_c;
  assign hz.if_flush       = if_flush_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if ((state_q != ST_BOOT) && !pc_write_c)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if ((state_q == ST_RUN) && if_flush_c)
        flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
`else
  assign hz.stall_cycles = 32'd0;
  assign hz.flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   exp_stalls;
  int   exp_flushes;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] ADD    = 32'h010A_4820; // add $9,$8,$10
  localparam logic [31:0] BEQ    = 32'h1109_0000; // beq $8,$9
  localparam logic [31:0] LW     = 32'h8D09_0000; // lw  $9,0($8)
  localparam logic [31:0] JMP    = 32'h0800_0010; // j   0x40

  hazard_ctrl_if hz ();

  hazard_ctrl #(.BOOT_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic pw, input logic iw,
                            input logic cc, input logic fl);
    chk({tag, ".pc_write"},       {31'd0, hz.pc_write},       {31'd0, pw});
    chk({tag, ".ifid_write"},     {31'd0, hz.ifid_write},     {31'd0, iw});
    chk({tag, ".c_clearControl"}, {31'd0, hz.c_clearControl}, {31'd0, cc});
    chk({tag, ".if_flush"},       {31'd0, hz.if_flush},       {31'd0, fl});
  endtask

  task automatic drive(input logic [31:0] ins, input logic ex_mr, input logic ex_rw,
                       input logic [4:0] ex_wr, input logic mem_mr,
                       input logic [4:0] mem_wr, input logic bt, input logic jp);
    hz.instru_id     = ins;
    hz.idex_memread  = ex_mr;
    hz.idex_regwrite = ex_rw;
    hz.idex_wreg     = ex_wr;
    hz.exmem_memread = mem_mr;
    hz.exmem_wreg    = mem_wr;
    hz.branch_taken  = bt;
    hz.jump          = jp;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_stalls  = 0;
    exp_flushes = 0;
    reset       = 1'b1;
    drive(NOP, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    expect_out("reset", 0, 0, 1, 1);
    chk("reset.stall_cycles", hz.stall_cycles, 32'd0);
    chk("reset.flush_count",  hz.flush_count,  32'd0);

    // Boot drain: exactly 3 cycles after reset release.
    reset = 1'b0;
    #1;
    expect_out("boot0", 0, 0, 1, 1);
    next_cycle(); #1;
    expect_out("boot1", 0, 0, 1, 1);
    next_cycle(); #1;
    expect_out("boot2", 0, 0, 1, 1);
    next_cycle(); #1;
    expect_out("run0", 1, 1, 0, 0);

    // Load-use on rs.
    drive(ADD, 1, 0, 5'd8, 0, 5'd0, 0, 0); #1;
    expect_out("lu_rs", 0, 0, 1, 0);
    exp_stalls++;
    next_cycle();
    // Register 0 never hazards.
    drive(ADD, 1, 0, 5'd0, 0, 5'd0, 0, 0); #1;
    expect_out("lu_r0", 1, 1, 0, 0);
    next_cycle();
    // Load-use on rt of an R-type.
    drive(ADD, 1, 0, 5'd10, 0, 5'd0, 0, 0); #1;
    expect_out("lu_rt", 0, 0, 1, 0);
    exp_stalls++;
    next_cycle();
    // lw does not read rt: no hazard on rt match.
    drive(LW, 1, 0, 5'd9, 0, 5'd0, 0, 0); #1;
    expect_out("lw_rt_nohaz", 1, 1, 0, 0);
    next_cycle();

    // Branch after lw in EX: RUN stall + one STALL cycle.
    drive(BEQ, 1, 0, 5'd9, 0, 5'd0, 0, 0); #1;
    expect_out("br_lw_c1", 0, 0, 1, 0);
    exp_stalls++;
    next_cycle();
    drive(BEQ, 1, 0, 5'd9, 0, 5'd0, 1, 0); #1;
    expect_out("br_lw_c2", 0, 0, 1, 0);
    exp_stalls++;
    next_cycle();
    drive(BEQ, 0, 0, 5'd0, 0, 5'd0, 1, 0); #1;
    expect_out("br_lw_go", 1, 1, 0, 1);
    exp_flushes++;
    next_cycle();

    // Branch after ALU writer in EX: 1 cycle.
    drive(BEQ, 0, 1, 5'd9, 0, 5'd0, 0, 0); #1;
    expect_out("br_alu_c1", 0, 0, 1, 0);
    exp_stalls++;
    next_cycle();
    drive(BEQ, 0, 0, 5'd0, 0, 5'd0, 0, 0); #1;
    expect_out("br_alu_go", 1, 1, 0, 0);
    next_cycle();

    // Branch after lw in MEM: 1 cycle.
    drive(BEQ, 0, 0, 5'd0, 1, 5'd8, 0, 0); #1;
    expect_out("br_mem_c1", 0, 0, 1, 0);
    exp_stalls++;
    next_cycle();

    // Jump, no hazard: flush for one cycle.
    drive(JMP, 0, 0, 5'd0, 0, 5'd0, 0, 1); #1;
    expect_out("jump", 1, 1, 0, 1);
    exp_flushes++;
    next_cycle();
    drive(NOP, 0, 0, 5'd0, 0, 5'd0, 0, 0); #1;
    expect_out("after_jump", 1, 1, 0, 0);
    next_cycle();

    // Stall dominates flush.
    drive(ADD, 1, 0, 5'd8, 0, 5'd0, 1, 1); #1;
    expect_out("stall_vs_flush", 0, 0, 1, 0);
    exp_stalls++;
    next_cycle();
    drive(NOP, 0, 0, 5'd0, 0, 5'd0, 0, 0); #1;

`ifdef HAZARD_PERF_CNT_EN
    chk("perf.stall_cycles", hz.stall_cycles, 32'(exp_stalls));
    chk("perf.flush_count",  hz.flush_count,  32'(exp_flushes));
`else
    chk("perf.stall_cycles", hz.stall_cycles, 32'd0);
    chk("perf.flush_count",  hz.flush_count,  32'd0);
`endif
    next_cycle();

    // Reset during STALL restarts BOOT.
    drive(BEQ, 1, 0, 5'd9, 0, 5'd0, 0, 0); #1;
    expect_out("rst_stall_c1", 0, 0, 1, 0);
    next_cycle();
    reset = 1'b1; #1;
    expect_out("rst_stall_c2", 0, 0, 1, 0);
    next_cycle();
    reset = 1'b0;
    drive(NOP, 0, 0, 5'd0, 0, 5'd0, 0, 0); #1;
    expect_out("reboot0", 0, 0, 1, 1);
    chk("reboot.stall_cycles", hz.stall_cycles, 32'd0);
    chk("reboot.flush_count",  hz.flush_count,  32'd0);
    next_cycle(); #1;
    expect_out("reboot1", 0, 0, 1, 1);
    next_cycle(); #1;
    expect_out("reboot2", 0, 0, 1, 1);
    next_cycle(); #1;
    expect_out("rerun", 1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
